d_inst_buffer: RTL and testbench

//  2-wide instruction buffer between the fetch stage (f_d_pkg_t producer) and the decoder.
//  - Accepts up to 2 insts/cycle with a per-slot mask and compacts valid slots into a circular queue.
//  - Presents the oldest 1-2 insts, slot 0 = oldest, to the decoder/rename handshake.
//  - Decouples fetch bubbles from decode and absorbs rename back-pressure; flushed on redirect.

---
 rtl/d_inst_buffer.sv | 125 ++++++++++++
 tb/tb_d_inst_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/d_inst_buffer.sv
// d_inst_buffer: 2-wide instruction buffer between fetch and decode.
// Fetch packets of up to two instructions are compacted into a circular
// queue. The oldest one or two entries are presented to the decoder, with
// slot 0 holding the oldest. A redirect (flush_i) empties the buffer.
// Optional feature: define D_IBUF_PERF_EN to add empty/full perf counters.
module d_inst_buffer #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_mask_i,
  input  logic [1:0][31:0] in_pc_i,
  input  logic [1:0][31:0] in_inst_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [1:0]       out_mask_o,
  output logic [1:0][31:0] out_pc_o,
  output logic [1:0][31:0] out_inst_o
`ifdef D_IBUF_PERF_EN
  ,
  output logic [31:0]      perf_empty_cnt_o,
  output logic [31:0]      perf_full_cnt_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_LIM = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [CNT_W-1:0] count;

  logic             enq_fire, deq_fire;
  logic [1:0]       enq_num, deq_num;

  // Number of set bits in a 2-bit slot mask.
  function automatic logic [1:0] pop2(input logic [1:0] m);
    return {m[1] & m[0], m[1] ^ m[0]};
  endfunction

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  // Space for a full two-wide packet is required regardless of its mask, so
  // acceptance depends only on the registered occupancy.
  assign in_ready_o  = (count <= READY_LIM);
  assign out_valid_o = (count != '0);

  assign enq_fire = in_valid_i & in_ready_o;
  assign deq_fire = out_valid_o & out_ready_i;
  assign enq_num  = enq_fire ? pop2(in_mask_i)  : 2'd0;
  assign deq_num  = deq_fire ? pop2(out_mask_o) : 2'd0;

  // Present the oldest one or two entries straight from the RAM.
  always_comb begin
    out_mask_o    = 2'b00;
    out_pc_o[0]   = mem[head].pc;
    out_inst_o[0] = mem[head].inst;
    out_pc_o[1]   = mem[head_p1].pc;
    out_inst_o[1] = mem[head_p1].inst;
    if (count >= CNT_W'(2))      out_mask_o = 2'b11;
    else if (count == CNT_W'(1)) out_mask_o = 2'b01;
  end

  // Write accepted slots at the tail, compacting a lone slot 1 down to tail.
  // NOTE: the storage array has no reset; only head/tail/count define which
  // entries are meaningful, so clearing the RAM would cost logic for nothing.
  always_ff @(posedge clk) begin
    if (enq_fire && !flush_i) begin
      if (in_mask_i[0]) mem[tail] <= '{pc: in_pc_i[0], inst: in_inst_i[0]};
      if (in_mask_i[1]) mem[in_mask_i[0] ? tail_p1 : tail] <= '{pc: in_pc_i[1], inst: in_inst_i[1]};
    end
  end

  // Advance pointers and occupancy; flush wins over any handshake.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_num);
      tail  <= tail + PTR_W'(enq_num);
      count <= count + CNT_W'(enq_num) - CNT_W'(deq_num);
    end
  end

`ifdef D_IBUF_PERF_EN
  // Saturating counters of empty cycles and back-pressured fetch cycles;
  // only rst clears them, a flush does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_empty_cnt_o <= '0;
      perf_full_cnt_o  <= '0;
    end else begin
      if (count == '0 && !flush_i && perf_empty_cnt_o != 32'hFFFF_FFFF)
        perf_empty_cnt_o <= perf_empty_cnt_o + 32'd1;
      if (in_valid_i && !in_ready_o && perf_full_cnt_o != 32'hFFFF_FFFF)
        perf_full_cnt_o <= perf_full_cnt_o + 32'd1;
    end
  end
`endif

  // Occupancy must never exceed capacity and must match the pointer distance.
  a_ptr_consistent : assert property (@(posedge clk) disable iff (rst)
    (count <= FULL_LVL) && (tail == head + PTR_W'(count)));

endmodule

// File: tb/tb_d_inst_buffer.sv
// tb_d_inst_buffer: self-checking bench for d_inst_buffer.
// A queue-based reference model holds the expected buffer contents; the
// driver issues directed then random fetch/decode traffic, and a monitor
// compares the DUT outputs against the model every cycle.
module tb_d_inst_buffer;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       in_mask_i;
  logic [1:0][31:0] in_pc_i;
  logic [1:0][31:0] in_inst_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [1:0]       out_mask_o;
  logic [1:0][31:0] out_pc_o;
  logic [1:0][31:0] out_inst_o;
`ifdef D_IBUF_PERF_EN
  logic [31:0]      perf_empty_cnt_o;
  logic [31:0]      perf_full_cnt_o;
  int unsigned      m_empty_cnt;
  int unsigned      m_full_cnt;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t model_q[$];

  always #5 clk = ~clk;

  d_inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_mask_i   (in_mask_i),
    .in_pc_i     (in_pc_i),
    .in_inst_i   (in_inst_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_mask_o  (out_mask_o),
    .out_pc_o    (out_pc_o),
    .out_inst_o  (out_inst_o)
`ifdef D_IBUF_PERF_EN
    ,
    .perf_empty_cnt_o (perf_empty_cnt_o),
    .perf_full_cnt_o  (perf_full_cnt_o)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus just after the falling edge.
  task automatic drive(input logic v, input logic [1:0] m, input logic rdy, input logic fl,
                       input logic [63:0] pcs, input logic [63:0] insts);
    in_valid_i  = v;
    in_mask_i   = m;
    out_ready_i = rdy;
    flush_i     = fl;
    in_pc_i     = pcs;
    in_inst_i   = insts;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: compare DUT against the model, then apply the handshakes that
  // will occur at the coming rising edge to the model.
  always @(negedge clk) begin
    int sz;
    logic exp_ready, exp_valid;
    logic [1:0] exp_mask;
    #2;
    if (rst) begin
      model_q.delete();
      check("rst_in_ready", 64'(in_ready_o), 64'd1);
      check("rst_out_valid", 64'(out_valid_o), 64'd0);
      check("rst_out_mask", 64'(out_mask_o), 64'd0);
`ifdef D_IBUF_PERF_EN
      m_empty_cnt = 0;
      m_full_cnt  = 0;
      check("rst_perf_empty", 64'(perf_empty_cnt_o), 64'd0);
      check("rst_perf_full", 64'(perf_full_cnt_o), 64'd0);
`endif
    end else begin
      sz        = model_q.size();
      exp_ready = (DEPTH - sz >= 2);
      exp_valid = (sz != 0);
      exp_mask  = (sz >= 2) ? 2'b11 : (sz == 1) ? 2'b01 : 2'b00;
      check("in_ready", 64'(in_ready_o), 64'(exp_ready));
      check("out_valid", 64'(out_valid_o), 64'(exp_valid));
      check("out_mask", 64'(out_mask_o), 64'(exp_mask));
      if (sz >= 1) check("slot0", {out_pc_o[0], out_inst_o[0]}, model_q[0]);
      if (sz >= 2) check("slot1", {out_pc_o[1], out_inst_o[1]}, model_q[1]);
`ifdef D_IBUF_PERF_EN
      check("perf_empty", 64'(perf_empty_cnt_o), 64'(m_empty_cnt));
      check("perf_full", 64'(perf_full_cnt_o), 64'(m_full_cnt));
      if (sz == 0 && !flush_i) m_empty_cnt++;
      if (in_valid_i && !exp_ready) m_full_cnt++;
`endif
      if (flush_i) begin
        model_q.delete();
      end else begin
        if (exp_valid && out_ready_i) begin
          void'(model_q.pop_front());
          if (sz >= 2) void'(model_q.pop_front());
        end
        if (in_valid_i && exp_ready) begin
          if (in_mask_i[0]) model_q.push_back('{pc: in_pc_i[0], inst: in_inst_i[0]});
          if (in_mask_i[1]) model_q.push_back('{pc: in_pc_i[1], inst: in_inst_i[1]});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    flush_i = 1'b0; in_valid_i = 1'b0; in_mask_i = '0; out_ready_i = 1'b0;
    in_pc_i = '0; in_inst_i = '0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;

    // Two-wide packet visible the next cycle, oldest in slot 0.
    drive(1'b1, 2'b11, 1'b0, 1'b0, {32'h1c000004, 32'h1c000000}, rnd64());
    drive(1'b0, 2'b00, 1'b0, 1'b0, rnd64(), rnd64());
    check("t1_pc0", 64'(out_pc_o[0]), 64'h1c000000);

    // Lone slot 1 is compacted into slot 0.
    drive(1'b0, 2'b00, 1'b0, 1'b1, rnd64(), rnd64());
    drive(1'b1, 2'b10, 1'b0, 1'b0, rnd64(), {32'h02800421, 32'h0});
    drive(1'b0, 2'b00, 1'b0, 1'b0, rnd64(), rnd64());
    check("t2_inst0", 64'(out_inst_o[0]), 64'h02800421);
    check("t2_mask", 64'(out_mask_o), 64'h1);

    // Fill to DEPTH-1 under back-pressure, then drain one pair.
    drive(1'b0, 2'b00, 1'b0, 1'b1, rnd64(), rnd64());
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b11, 1'b0, 1'b0, rnd64(), rnd64());
    drive(1'b1, 2'b01, 1'b0, 1'b0, rnd64(), rnd64());
    check("t3_full_ready", 64'(in_ready_o), 64'd0);
    drive(1'b1, 2'b01, 1'b1, 1'b0, rnd64(), rnd64());
    check("t3_drain_ready", 64'(in_ready_o), 64'd1);

    // Flush with simultaneous enqueue and dequeue discards everything.
    drive(1'b1, 2'b11, 1'b1, 1'b1, rnd64(), rnd64());
    check("t5_valid", 64'(out_valid_o), 64'd0);
    check("t5_ready", 64'(in_ready_o), 64'd1);

    // Idle run exercising the empty counter.
    repeat (10) drive(1'b0, 2'b00, 1'b1, 1'b0, rnd64(), rnd64());

    // Random traffic covering wrap, stalls and flushes, with a mid-run reset.
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid_o), 64'd0);
        check("midrst_mask", 64'(out_mask_o), 64'd0);
        check("midrst_ready", 64'(in_ready_o), 64'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
      end
      drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 5), ($urandom_range(0, 99) < 3), rnd64(), rnd64());
    end

    repeat (3) drive(1'b0, 2'b00, 1'b1, 1'b0, rnd64(), rnd64());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
